// File: rtl/frame_fifo_wr_arb_if.sv
// Purpose: producer-to-FIFO write bundle for frame_fifo_wr_arb.
// master: arbiter side (takes requester lanes and FIFO overflow, drives
//         ready/grant, FIFO write port, frame pulses and counters).
// slave : environment side (requesters + frame FIFO).
interface frame_fifo_wr_arb_if #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DATAWIDTH = 8
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*DATAWIDTH-1:0] req_data;
  logic [NREQ-1:0]           req_last;
  logic [NREQ-1:0]           req_abort;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           grant;
  logic [DATAWIDTH-1:0]      fifo_wr_data;
  logic                      fifo_we;
  logic                      fifo_commit;
  logic                      fifo_rollback;
  logic                      fifo_ovf;
  logic                      frame_ok;
  logic                      frame_drop;
  logic [15:0]               ok_count;
  logic [15:0]               drop_count;

  modport master (
    input  req_valid, req_data, req_last, req_abort, fifo_ovf,
    output req_ready, grant, fifo_wr_data, fifo_we, fifo_commit,
           fifo_rollback, frame_ok, frame_drop, ok_count, drop_count
  );

  modport slave (
    output req_valid, req_data, req_last, req_abort, fifo_ovf,
    input  req_ready, grant, fifo_wr_data, fifo_we, fifo_commit,
           fifo_rollback, frame_ok, frame_drop, ok_count, drop_count
  );
endinterface

// File: rtl/frame_fifo_wr_arb.sv
// Purpose: round-robin write-side scheduler sharing one commit/rollback frame
// FIFO between NREQ producers. Forwards the owner's words whole-frame, then
// closes the frame with commit, or rollback on overflow/abort/stall timeout.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   bus (master)  : requester lanes (valid/data/last/abort, ready comb),
//                   grant, FIFO write port (wr_data/we/commit/rollback/ovf),
//                   frame_ok/frame_drop pulses, saturating ok/drop counters
module frame_fifo_wr_arb #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic                 clk,
  input logic                 reset,
  frame_fifo_wr_arb_if.master bus
);

  localparam int unsigned IDXW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned STALLW = $clog2(TIMEOUT + 1);
  localparam int unsigned CNTW   = 16;

  typedef enum logic [1:0] {IDLE, XFER, FLUSH, CHECK} state_t;

  state_t                 state_q, state_nxt;
  logic [IDXW-1:0]        rr_q, rr_nxt;          // last granted = current owner
  logic [NREQ-1:0]        grant_q, grant_nxt;
  logic [STALLW-1:0]      stall_q, stall_nxt;
  logic                   bad_q, bad_nxt;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_nxt;
  logic                   we_q, we_nxt;
  logic                   commit_q, commit_nxt;
  logic                   rollback_q, rollback_nxt;
  logic [CNTW-1:0]        ok_q, ok_nxt;
  logic [CNTW-1:0]        drop_q, drop_nxt;
  logic [NREQ-1:0]        ready_c;
  logic                   accept_c;
  logic                   hit_c;
  logic [IDXW-1:0]        hit_idx_c;

  // Round-robin scan starting just after the previous owner.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!hit_c && bus.req_valid[IDXW'((32'(rr_q) + k) % NREQ)]) begin
        hit_c     = 1'b1;
        hit_idx_c = IDXW'((32'(rr_q) + k) % NREQ);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt    = state_q;
    rr_nxt       = rr_q;
    grant_nxt    = grant_q;
    stall_nxt    = stall_q;
    bad_nxt      = bad_q;
    wdata_nxt    = wdata_q;
    we_nxt       = 1'b0;
    commit_nxt   = 1'b0;
    rollback_nxt = 1'b0;
    ok_nxt       = ok_q;
    drop_nxt     = drop_q;
    ready_c      = '0;
    accept_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit_c) begin
          state_nxt = XFER;
          rr_nxt    = hit_idx_c;
          grant_nxt = NREQ'(1) << hit_idx_c;
          stall_nxt = '0;
          bad_nxt   = 1'b0;
        end
      end

      XFER: begin
        bad_nxt           = bad_q | bus.fifo_ovf;
        accept_c          = bus.req_valid[rr_q] & ~bus.req_abort[rr_q];
        ready_c[rr_q]     = accept_c;
        // Abort and stall timeout both discard the partial frame.
        if (bus.req_abort[rr_q] ||
            (!accept_c && stall_q == STALLW'(TIMEOUT - 1))) begin
          rollback_nxt = 1'b1;
          drop_nxt     = (drop_q == '1) ? drop_q : drop_q + 1'b1;
          grant_nxt    = '0;
          bad_nxt      = 1'b0;
          stall_nxt    = '0;
          state_nxt    = IDLE;
        end else if (accept_c) begin
          we_nxt    = 1'b1;
          wdata_nxt = bus.req_data[rr_q*DATAWIDTH +: DATAWIDTH];
          stall_nxt = '0;
          if (bus.req_last[rr_q]) begin
            state_nxt = FLUSH;
          end
        end else begin
          stall_nxt = stall_q + 1'b1;
        end
      end

      FLUSH: begin
        bad_nxt   = bad_q | bus.fifo_ovf;
        state_nxt = CHECK;
      end

      CHECK: begin
        // Overflow flag for the final word is visible only now.
        if (bad_q || bus.fifo_ovf) begin
          rollback_nxt = 1'b1;
          drop_nxt     = (drop_q == '1) ? drop_q : drop_q + 1'b1;
        end else begin
          commit_nxt = 1'b1;
          ok_nxt     = (ok_q == '1) ? ok_q : ok_q + 1'b1;
        end
        bad_nxt   = 1'b0;
        grant_nxt = '0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= IDXW'(NREQ - 1);
      grant_q    <= '0;
      stall_q    <= '0;
      bad_q      <= 1'b0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      commit_q   <= 1'b0;
      rollback_q <= 1'b0;
      ok_q       <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_nxt;
      rr_q       <= rr_nxt;
      grant_q    <= grant_nxt;
      stall_q    <= stall_nxt;
      bad_q      <= bad_nxt;
      wdata_q    <= wdata_nxt;
      we_q       <= we_nxt;
      commit_q   <= commit_nxt;
      rollback_q <= rollback_nxt;
      ok_q       <= ok_nxt;
      drop_q     <= drop_nxt;
    end
  end

  assign bus.req_ready     = ready_c;
  assign bus.grant         = grant_q;
  assign bus.fifo_wr_data  = wdata_q;
  assign bus.fifo_we       = we_q;
  assign bus.fifo_commit   = commit_q;
  assign bus.fifo_rollback = rollback_q;
  assign bus.frame_ok      = commit_q;
  assign bus.frame_drop    = rollback_q;
  assign bus.ok_count      = ok_q;
  assign bus.drop_count    = drop_q;

endmodule

// File: doc/frame_fifo_wr_arb.md
Name: frame_fifo_wr_arb

Overview:
Write-side scheduler that shares one frame FIFO (commit/rollback type) between NREQ frame producers. It grants one requester at a time, round-robin, and forwards that requester's words whole-frame into the FIFO. It ends each frame with a commit pulse, or with a rollback pulse on FIFO overflow, requester abort, or stall timeout. It sits between producer logic and the frame FIFO write port.

Parameters:
NREQ, 4, number of requesters (2..16)
DATAWIDTH, 8, data word width
TIMEOUT, 255, max consecutive non-accepting cycles in mid-frame before forced drop (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active high
req_valid  in  NREQ  requester i has a word on its data lane
req_data  in  NREQ*DATAWIDTH  lane i = bits [i*DATAWIDTH +: DATAWIDTH]
req_last  in  NREQ  word on lane i is last of frame
req_abort  in  NREQ  requester i abandons current frame
req_ready  out  NREQ  word accepted this cycle (combinational)
grant  out  NREQ  one-hot current owner, registered
fifo_wr_data  out  DATAWIDTH  to FIFO wr_data, registered
fifo_we  out  1  to FIFO we, registered
fifo_commit  out  1  to FIFO commit, 1-cycle pulse
fifo_rollback  out  1  to FIFO rollback, 1-cycle pulse
fifo_ovf  in  1  FIFO overflow; high the cycle after a fifo_we whose word was dropped
frame_ok  out  1  pulse, coincident with fifo_commit
frame_drop  out  1  pulse, coincident with fifo_rollback
ok_count  out  16  saturating count of committed frames
drop_count  out  16  saturating count of rolled-back frames

Behaviour:
- Reset, synchronous and active high: state IDLE, grant=0, all fifo_* outputs 0, pulses 0, counters 0, bad=0, rr pointer=NREQ-1 so requester 0 wins first.
- States: IDLE, XFER, FLUSH, CHECK.
- IDLE: scan req_valid from rr+1, wrapping modulo NREQ. On the first hit g: grant<=onehot(g), rr<=g, go to XFER. No hit: stay in IDLE. req_abort is ignored in IDLE.
- XFER: req_ready[g] = req_valid[g] & !req_abort[g]. All other ready bits are 0.
- On accept: fifo_we<=1 and fifo_wr_data<=lane g next cycle. The stall counter clears.
- Accept with req_last: go to FLUSH.
- req_abort[g] wins over valid; no word is taken. Next cycle: fifo_rollback=1, frame_drop=1, grant<=0, state IDLE.
- No accept: stall counter increments. When it reaches TIMEOUT, act exactly as an abort.
- FLUSH: the last word is on fifo_we. Go to CHECK.
- CHECK: the overflow result of the last write is visible. Next cycle: if bad|fifo_ovf then fifo_rollback=1 and frame_drop=1, else fifo_commit=1 and frame_ok=1. grant<=0, state IDLE.
- bad: set by fifo_ovf in any cycle from XFER entry through CHECK. Cleared when the frame ends.
- Latency: word accepted at cycle t reaches fifo_we at t+1. commit/rollback comes 3 cycles after acceptance of the last word.
- Minimum gap from one frame's commit to the next frame's first fifo_we: 2 cycles.
- fifo_commit and fifo_rollback are never both high. Neither is ever high in the same cycle as fifo_we.
- A single-word frame (valid&last on the first accept) is legal.
- Counters saturate at 16'hFFFF. Each increments in the same cycle as its pulse.
- Reset during a frame: no commit or rollback is issued. The FIFO shares this reset and clears itself.
- Fairness: a requester that just finished has lowest priority in the next arbitration.

Test Plan:
- Req0 sends 8-word frame 1..8 with last on 8, FIFO empty -> fifo_we 8 consecutive cycles with data 1..8; fifo_commit 3 cycles after last accept; ok_count=1.
- Req0, Req2 valid continuously, single-word frames -> grant order 0,2,0,2; grants 0 and 2 each at least 4 times in 10 frames.
- Req1 sends 9 words into 8-deep FIFO; fifo_ovf pulses after the 9th write -> fifo_rollback (not commit) at end of frame; drop_count=1.
- Req3 writes 3 words, then req_abort together with req_valid -> 4th word not accepted (ready=0); rollback next cycle; state IDLE; grant=0.
- TIMEOUT=4, req0 writes 2 words then drops valid -> rollback exactly 4 stall cycles later; frame_drop=1.
- Reset asserted mid-frame -> next cycle all outputs 0, no commit/rollback pulse; the next arbitration grants req0 first.
